// File: rtl/apb_mig_pkg.sv
// rtl/apb_mig_pkg.sv - shared types, widths and FSM states for the APB to MIG bridge
package apb_mig_pkg;
   localparam int MIG_ADDR_WIDTH = 27;

   typedef logic [31:0]               data_t;
   typedef logic [3:0]                strb_t;
   typedef logic [MIG_ADDR_WIDTH-1:0] mig_addr_t;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, RESP} state_e;
endpackage

// File: rtl/apb_mig_ctrl_if.sv
// rtl/apb_mig_ctrl_if.sv - MIG user-side request/response bundle
// apb is the bridge side, mig is the memory-controller side.
interface mig_if;
   import apb_mig_pkg::*;

   logic      en_o;
   logic      w_en_o;
   mig_addr_t addr_o;
   strb_t     strb_o;
   data_t     data_o;
   data_t     data_i;
   logic      valid_i;
   logic      ready_i;
   logic      w_ready_i;

   modport apb (output en_o, w_en_o, addr_o, strb_o, data_o,
                input  data_i, valid_i, ready_i, w_ready_i);
   modport mig (input  en_o, w_en_o, addr_o, strb_o, data_o,
                output data_i, valid_i, ready_i, w_ready_i);
endinterface

// File: rtl/apb_mig_timeout.sv
// rtl/apb_mig_timeout.sv - saturating cycle counter with clear, enable and expiry flag
// expired_o rises in the cycle whose increment makes the count reach MAX.
module apb_mig_timeout #(
   parameter int MAX = 1023
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int W = $clog2(MAX + 2);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i && (count_q != W'(MAX))) begin
         count_d = count_q + 1'b1;
      end
   end

   assign expired_o = (count_d == W'(MAX));

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end
endmodule

// File: rtl/apb_mig_ctrl.sv
// rtl/apb_mig_ctrl.sv - APB slave bridging single-beat accesses onto the MIG user port
module apb_mig_ctrl
   import apb_mig_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int APB_ADDR_WIDTH = 32
) (
   input  logic                      ui_clk_i,
   input  logic                      ui_reset_ni,
   input  logic                      psel_i,
   input  logic                      penable_i,
   input  logic                      pwrite_i,
   input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
   input  data_t                     pwdata_i,
   input  strb_t                     pstrb_i,
   output logic                      pready_o,
   output data_t                     prdata_o,
   output logic                      pslverr_o,
   mig_if.apb                        mig
);
   state_e    state_q, state_d;
   logic      en_q, en_d, w_en_q, w_en_d;
   logic      pready_q, pready_d, pslverr_q, pslverr_d;
   mig_addr_t addr_q, addr_d;
   data_t     data_q, data_d, prdata_q, prdata_d;
   strb_t     strb_q, strb_d;
   logic      setup, addr_ok, go_req, busy, expired;

   assign setup   = psel_i && !penable_i;
   assign addr_ok = (paddr_i[1:0] == 2'b00) && ((paddr_i >> MIG_ADDR_WIDTH) == '0);
   assign go_req  = (state_q == IDLE) && setup && addr_ok;
   assign busy    = (state_q == REQ) || (state_q == WAIT_RD);

   apb_mig_timeout #(.MAX(TIMEOUT_CYCLES)) u_timeout (
      .clk_i     (ui_clk_i),
      .rst_ni    (ui_reset_ni),
      .clr_i     (go_req),
      .en_i      (busy),
      .expired_o (expired)
   );

   // Response fields are only non-zero for the single RESP cycle.
   always_comb begin
      state_d   = state_q;
      en_d      = en_q;
      w_en_d    = w_en_q;
      addr_d    = addr_q;
      data_d    = data_q;
      strb_d    = strb_q;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      prdata_d  = '0;
      case (state_q)
         IDLE: begin
            if (setup) begin
               if (addr_ok) begin
                  state_d = REQ;
                  en_d    = 1'b1;
                  w_en_d  = pwrite_i;
                  addr_d  = paddr_i[MIG_ADDR_WIDTH-1:0];
                  data_d  = pwdata_i;
                  strb_d  = pstrb_i;
               end else begin
                  state_d   = RESP;
                  pready_d  = 1'b1;
                  pslverr_d = 1'b1;
               end
            end
         end
         REQ: begin
            // w_en_q doubles as the latched pwrite while the request is open.
            if (mig.ready_i && (!w_en_q || mig.w_ready_i)) begin
               en_d    = 1'b0;
               w_en_d  = 1'b0;
               if (w_en_q) begin
                  state_d  = RESP;
                  pready_d = 1'b1;
               end else begin
                  state_d = WAIT_RD;
               end
            end else if (expired) begin
               state_d   = RESP;
               en_d      = 1'b0;
               w_en_d    = 1'b0;
               pready_d  = 1'b1;
               pslverr_d = 1'b1;
            end
         end
         WAIT_RD: begin
            if (mig.valid_i) begin
               state_d  = RESP;
               pready_d = 1'b1;
               prdata_d = mig.data_i;
            end else if (expired) begin
               state_d   = RESP;
               pready_d  = 1'b1;
               pslverr_d = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ui_clk_i) begin
      if (!ui_reset_ni) begin
         state_q   <= IDLE;
         en_q      <= 1'b0;
         w_en_q    <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         en_q      <= en_d;
         w_en_q    <= w_en_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         strb_q    <= strb_d;
         pready_q  <= pready_d;
         pslverr_q <= pslverr_d;
         prdata_q  <= prdata_d;
      end
   end

   assign pready_o   = pready_q;
   assign pslverr_o  = pslverr_q;
   assign prdata_o   = prdata_q;
   assign mig.en_o   = en_q;
   assign mig.w_en_o = w_en_q;
   assign mig.addr_o = addr_q;
   assign mig.data_o = data_q;
   assign mig.strb_o = strb_q;
endmodule

// File: tb/tb_apb_mig_ctrl.sv
// tb/tb_apb_mig_ctrl.sv - randomized scoreboard bench for apb_mig_ctrl
module tb_apb_mig_ctrl;
   import apb_mig_pkg::*;

   localparam int T = 15;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0] paddr = '0;
   data_t       pwdata = '0;
   strb_t       pstrb = '0;
   logic        pready, pslverr;
   data_t       prdata;

   mig_if mif();

   int total = 0;
   int bad = 0;
   int cyc = 0;

   typedef struct {
      logic  err;
      data_t rd;
      int    cyc;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   apb_mig_ctrl #(.TIMEOUT_CYCLES(T), .APB_ADDR_WIDTH(32)) dut (
      .ui_clk_i    (clk),
      .ui_reset_ni (resetn),
      .psel_i      (psel),
      .penable_i   (penable),
      .pwrite_i    (pwrite),
      .paddr_i     (paddr),
      .pwdata_i    (pwdata),
      .pstrb_i     (pstrb),
      .pready_o    (pready),
      .prdata_o    (prdata),
      .pslverr_o   (pslverr),
      .mig         (mif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Response monitor: pops one expectation per pready pulse.
   always @(negedge clk) begin
      if (pready === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("spurious_pready", 32'(pready), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("pslverr", 32'(pslverr), 32'(mon_e.err));
            chk("prdata", prdata, mon_e.rd);
            chk("pready_cycle", 32'(cyc), 32'(mon_e.cyc));
         end
      end else begin
         chk("pslverr_idle", 32'(pslverr), 32'd0);
         chk("prdata_idle", prdata, 32'd0);
      end
   end

   task automatic xfer(input bit wr, input logic [31:0] addr, input data_t wd, input strb_t st,
                       input int ra, input int wa, input int v, input data_t rd);
      bit    good, err, seen, exp_en;
      int    a, lim, comp, en_last;
      data_t exp_rd;
      good   = (addr[1:0] == 2'b00) && (addr[31:27] == 5'd0);
      a      = (wr && wa > ra) ? wa : ra;
      lim    = (a + 1 > T) ? a + 1 : T;
      exp_rd = '0;
      err    = 1'b1;
      if (!good) begin
         comp = 0; en_last = 0;
      end else if (a > T) begin
         comp = T; en_last = T;
      end else begin
         en_last = a;
         if (wr) begin
            comp = a; err = 1'b0;
         end else if (v > a && v <= lim) begin
            comp = v; err = 1'b0; exp_rd = rd;
         end else begin
            comp = lim;
         end
      end
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
      mif.ready_i = 1'b0; mif.w_ready_i = 1'b0; mif.valid_i = 1'b0;
      exp_q.push_back('{err, exp_rd, cyc + 1 + comp});
      seen = 1'b0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clk);
         exp_en = good && (k <= en_last);
         chk("en_o", 32'(mif.en_o), 32'(exp_en));
         chk("w_en_o", 32'(mif.w_en_o), 32'(exp_en && wr));
         if (exp_en) begin
            chk("addr_o", 32'(mif.addr_o), {5'd0, addr[26:0]});
            chk("data_o", mif.data_o, wd);
            chk("strb_o", 32'(mif.strb_o), 32'(st));
         end
         seen = (pready === 1'b1);
         penable = 1'b1;
         mif.ready_i   = (k >= ra);
         mif.w_ready_i = (k >= wa);
         mif.valid_i   = (k == v);
         mif.data_i    = (k == v) ? rd : $urandom;
      end
      if (!seen) begin
         total++; bad++;
         $display("FAIL pready_wait: actual=none required=pready within 40 cycles");
         void'(exp_q.pop_back());
      end
   endtask

   task automatic idle(input int n, input bit vpulse);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         psel = 1'b0; penable = 1'b0;
         mif.ready_i = 1'b0; mif.w_ready_i = 1'b0;
         mif.valid_i = vpulse && (i < 2);
         mif.data_i  = $urandom;
         chk("idle_en_o", 32'(mif.en_o), 32'd0);
      end
   endtask

   task automatic reset_mid_read();
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h80; pstrb = 4'hF;
      mif.ready_i = 1'b0; mif.valid_i = 1'b0;
      @(negedge clk);
      penable = 1'b1; mif.ready_i = 1'b1;
      repeat (2) begin
         @(negedge clk);
         mif.ready_i = 1'b0;
      end
      @(negedge clk);
      resetn = 1'b0; psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      chk("rst_en_o", 32'(mif.en_o), 32'd0);
      chk("rst_w_en_o", 32'(mif.w_en_o), 32'd0);
      chk("rst_pready", 32'(pready), 32'd0);
      chk("rst_addr_o", 32'(mif.addr_o), 32'd0);
      chk("rst_data_o", mif.data_o, 32'd0);
      chk("rst_strb_o", 32'(mif.strb_o), 32'd0);
      resetn = 1'b1;
      idle(20, 1'b1);
   endtask

   initial begin
      bit          wr;
      int          sel;
      logic [31:0] addr;
      mif.data_i = '0; mif.valid_i = 1'b0; mif.ready_i = 1'b0; mif.w_ready_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_pready", 32'(pready), 32'd0);
      chk("reset_en_o", 32'(mif.en_o), 32'd0);
      chk("reset_w_en_o", 32'(mif.w_en_o), 32'd0);
      chk("reset_addr_o", 32'(mif.addr_o), 32'd0);
      resetn = 1'b1;

      xfer(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 1, 1, 0, 32'h0);
      xfer(1'b0, 32'h0000_0040, 32'h0, 4'hF, 1, 1, 6, 32'hCAFE_F00D);
      xfer(1'b1, 32'h0000_2000, 32'h1234_5678, 4'h3, 1, 11, 0, 32'h0);
      xfer(1'b0, 32'h0000_0080, 32'h0, 4'hF, 1, 1, 0, 32'h0);
      idle(4, 1'b1);
      xfer(1'b1, 32'h0000_0002, 32'h1111_2222, 4'hF, 1, 1, 0, 32'h0);
      xfer(1'b0, 32'h1000_0000, 32'h0, 4'hF, 1, 1, 3, 32'h3333_4444);
      xfer(1'b1, 32'h0000_0300, 32'hA5A5_5A5A, 4'h9, T, T, 0, 32'h0);
      xfer(1'b1, 32'h0000_0304, 32'h0F0F_F0F0, 4'h6, T + 1, 1, 0, 32'h0);
      xfer(1'b0, 32'h0000_0308, 32'h0, 4'hF, T, 1, T + 1, 32'h7777_8888);
      reset_mid_read();
      xfer(1'b0, 32'h0000_0100, 32'h0, 4'hF, 2, 1, 4, 32'h55AA_1234);

      for (int i = 0; i < 40; i++) begin
         wr   = 1'($urandom_range(0, 1));
         sel  = int'($urandom_range(0, 9));
         addr = {5'd0, 27'($urandom)} & ~32'h3;
         if (sel == 0) addr[1:0] = 2'($urandom_range(1, 3));
         else if (sel == 1) addr[31:27] = 5'($urandom_range(1, 31));
         xfer(wr, addr, $urandom, 4'($urandom), int'($urandom_range(1, 17)),
              int'($urandom_range(1, 17)), int'($urandom_range(0, 18)), $urandom);
      end
      idle(3, 1'b0);
      chk("unmatched_expectations", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/apb_mig_ctrl.md
APB_MIG_CTRL -- requirements
Module: apb_mig_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 1023, cycles allowed in REQ or WAIT_RD before the transfer errors out.
REQ-002 Parameter: APB_ADDR_WIDTH, 32, width of paddr_i.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 Port: ui_clk_i, input, 1, the only clock; all logic is on its rising edge.
REQ-005 Port: ui_reset_ni, input, 1, synchronous active-low reset.
REQ-006 APB slave ports: psel_i 1, penable_i 1, pwrite_i 1, paddr_i APB_ADDR_WIDTH, pwdata_i data_t, pstrb_i strb_t, all inputs.
REQ-007 APB slave ports: pready_o 1, prdata_o data_t, pslverr_o 1, all outputs.
REQ-008 MIG-side inputs: data_i data_t, valid_i 1, ready_i 1, w_ready_i 1.
REQ-009 MIG-side outputs: en_o 1, w_en_o 1, addr_o mig_addr_t, strb_o strb_t, data_o data_t.

Function
REQ-010 The FSM SHALL have four states: IDLE, REQ, WAIT_RD and RESP.
REQ-011 IDLE -> REQ when psel_i=1 and penable_i=0 (APB setup phase) and the address check passes; this edge latches paddr, pwrite, pwdata and pstrb.
REQ-012 The address check SHALL fail when paddr_i[1:0] != 0 or any paddr_i bit at or above MIG_ADDR_WIDTH is nonzero.
REQ-013 On a failed address check: IDLE -> RESP with pslverr latched to 1; no MIG request is issued.
REQ-014 In REQ, en_o=1 and w_en_o = latched pwrite; addr_o, data_o and strb_o are driven from the latches and held stable.
REQ-015 A write is accepted on the first cycle with ready_i=1 and w_ready_i=1: REQ -> RESP.
REQ-016 A read is accepted on the first cycle with ready_i=1: REQ -> WAIT_RD.
REQ-017 In WAIT_RD, en_o=0; the first cycle with valid_i=1 captures data_i into prdata and goes to RESP.
REQ-018 valid_i SHALL be ignored in every state other than WAIT_RD.
REQ-019 In RESP, pready_o=1 for exactly one cycle, then -> IDLE; pslverr_o and prdata_o are valid only while pready_o=1 and are 0 otherwise.
REQ-020 Latency: a write with ready_i and w_ready_i held at 1 gives pready_o 2 cycles after the setup edge.
REQ-021 The timeout counter SHALL clear on entry to REQ and increment each cycle in REQ or WAIT_RD.
REQ-022 When the counter reaches TIMEOUT_CYCLES: go to RESP, pslverr=1, prdata=0, en_o=0 next cycle; the counter saturates and never wraps.
REQ-023 Acceptance and timeout in the same cycle: acceptance wins.
REQ-024 en_o and w_en_o SHALL be registered outputs, with no combinational path from any APB input.
REQ-025 APB inputs arriving while the FSM is not IDLE SHALL be ignored, since APB cannot issue a new setup before pready.

Reset
REQ-026 While ui_reset_ni=0 at a clock edge: FSM -> IDLE; en_o, w_en_o, pready_o, pslverr_o = 0; addr_o, data_o, strb_o, prdata_o = 0; counter = 0.
REQ-027 Reset asserted mid-transfer SHALL abandon the transfer; no pready_o is produced for it after reset releases.

Structure
REQ-028 data_t (32 b), strb_t (4 b), mig_addr_t (27 b), MIG_ADDR_WIDTH and the FSM state enum SHALL live in apb_mig_pkg.
REQ-029 The MIG-side ports SHALL be connectable to the apb modport of mig_if without adaptation logic.
REQ-030 One sub-module, apb_mig_timeout (saturating counter with clear, enable and expired flag), SHALL be used.

Verification
REQ-031 Write 0x0000_1000, pwdata 0xDEADBEEF, pstrb 0xF, ready_i=w_ready_i=1 -> en_o=w_en_o=1 for one cycle, addr_o=0x1000, pready_o on the next cycle, pslverr_o=0.
REQ-032 Read 0x0000_0040, ready_i=1, valid_i after 5 cycles with data_i 0xCAFEF00D -> prdata_o=0xCAFEF00D with pready_o, pslverr_o=0.
REQ-033 Write with w_ready_i=0 for 10 cycles, then 1 -> en_o and all request fields held stable for 11 cycles, then one pready_o.
REQ-034 Read with TIMEOUT_CYCLES=15 and valid_i never asserted -> pready_o=1, pslverr_o=1, prdata_o=0 after 16 cycles; a valid_i pulse afterwards in IDLE has no effect.
REQ-035 Address 0x0000_0002, and separately address 0x1000_0000 -> pslverr_o=1, en_o never asserted.
REQ-036 ui_reset_ni=0 for one cycle while in WAIT_RD -> all outputs 0 the next cycle, no pready_o, and a following read completes normally.
